// File: rtl/sw_key_pkg.sv
// Shared constants and state encoding for the slide-switch key encoder.
package sw_key_pkg;

  localparam int NUM_SW              = 10;
  localparam int KEY_W               = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } key_state_e;

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-flop synchronizer, stability counter and debounced level.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw_stable
);

  localparam int                CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_TC = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;

  // Bring the asynchronous switch level into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count how long the synchronized level has disagreed with the accepted
  // level; accept the new level once it has held for the full window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_TC) begin
      r_stable <= ~r_stable;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sw_stable = r_stable;

endmodule

// File: rtl/sw_key_encoder.sv
// Debounces the slide switches and turns single clean presses into key codes.
//
// state | meaning
// IDLE  | all debounced switches low; a lone press is accepted as a key
// HELD  | at least one switch high; any further press is rejected
module sw_key_encoder
  import sw_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int NUM_SW          = sw_key_pkg::NUM_SW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] SW,
  output logic              key_valid,
  output logic [KEY_W-1:0]  key_code,
  output logic              key_err,
  output logic [NUM_SW-1:0] sw_stable
);

  logic [NUM_SW-1:0] w_stable;
  logic [NUM_SW-1:0] w_rise;
  logic              w_any;
  logic              w_multi;
  logic [KEY_W-1:0]  w_idx;

  logic [NUM_SW-1:0] r_stable_d;
  key_state_e        r_state;
  logic              r_key_valid;
  logic              r_key_err;
  logic [KEY_W-1:0]  r_key_code;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_deb
    sw_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .sw_raw    (SW[g]),
      .sw_stable (w_stable[g])
    );
  end

  assign w_rise = w_stable & ~r_stable_d;

  // Classify this cycle's press events: none, exactly one (with its index), or several.
  always_comb begin
    w_any   = 1'b0;
    w_multi = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (w_rise[i]) begin
        if (w_any) w_multi = 1'b1;
        w_any = 1'b1;
        w_idx = KEY_W'(i);
      end
    end
  end

  // Key FSM with registered pulse outputs; key_code holds between accepts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_stable_d  <= '0;
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_stable_d  <= w_stable;
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_multi) begin
            r_key_err <= 1'b1;
            r_state   <= ST_HELD;
          end else if (w_any) begin
            r_key_valid <= 1'b1;
            r_key_code  <= w_idx;
            r_state     <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (w_any) begin
            r_key_err <= 1'b1;
          end else if (w_stable == '0) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign key_valid = r_key_valid;
  assign key_err   = r_key_err;
  assign key_code  = r_key_code;
  assign sw_stable = w_stable;

endmodule

// File: tb/tb_sw_key_encoder.sv
// Directed bench for sw_key_encoder at DEBOUNCE_CYCLES=16, 20 ns clock.
module tb_sw_key_encoder;

  localparam int LAT = 20;

  logic       clk;
  logic       rst;
  logic [9:0] SW;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_err;
  logic [9:0] sw_stable;

  int n_vec  = 0;
  int n_miss = 0;

  int cyc       = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  int valid_cyc = 0;
  int last_code = 0;

  sw_key_encoder #(
    .DEBOUNCE_CYCLES (16),
    .NUM_SW          (10)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .SW        (SW),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_err   (key_err),
    .sw_stable (sw_stable)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (key_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      last_code = int'(key_code);
    end
    if (key_err) err_cnt++;
    if (key_valid && key_err) both_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press one switch for 50 cycles, release, and check one clean key.
  task automatic single_press(input int idx);
    int v0, e0, e1;
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    SW[idx] = 1'b1;
    e1 = cyc + 1;
    cycles(50);
    SW[idx] = 1'b0;
    cycles(40);
    check($sformatf("press%0d_valid", idx), valid_cnt - v0, 1);
    check($sformatf("press%0d_code", idx), last_code, idx);
    check($sformatf("press%0d_lat", idx), valid_cyc - e1 + 1, LAT);
    check($sformatf("press%0d_err", idx), err_cnt - e0, 0);
  endtask

  initial begin
    int v0, e0, e1, hi;
    rst = 1'b0;
    SW  = '0;

    // Reset held low with switches idle.
    cycles(5);
    check("rst_valid", int'(key_valid), 0);
    check("rst_err", int'(key_err), 0);
    check("rst_code", int'(key_code), 0);
    check("rst_stable", int'(sw_stable), 0);
    cycles(45);
    rst = 1'b1;
    cycles(30);
    check("idle_valid_cnt", valid_cnt, 0);
    check("idle_err_cnt", err_cnt, 0);
    check("idle_stable", int'(sw_stable), 0);

    single_press(2);
    single_press(0);
    single_press(1);
    single_press(6);

    // Short glitch on SW[3].
    v0 = valid_cnt;
    hi = 0;
    @(negedge clk);
    SW[3] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (sw_stable[3]) hi = 1;
    end
    SW[3] = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (sw_stable[3]) hi = 1;
    end
    check("glitch_stable3", hi, 0);
    check("glitch_valid", valid_cnt - v0, 0);

    // Two switches on the same edge.
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    SW[4] = 1'b1;
    SW[5] = 1'b1;
    cycles(50);
    check("dual_err", err_cnt - e0, 1);
    check("dual_valid", valid_cnt - v0, 0);
    check("dual_code", int'(key_code), 6);
    check("dual_stable", int'(sw_stable), 10'h030);
    SW = '0;
    cycles(40);
    check("dual_release", int'(sw_stable), 0);

    // Held key then a second press.
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    SW[7] = 1'b1;
    e1 = cyc + 1;
    cycles(40);
    check("hold7_valid", valid_cnt - v0, 1);
    check("hold7_code", last_code, 7);
    check("hold7_lat", valid_cyc - e1 + 1, LAT);
    SW[8] = 1'b1;
    cycles(50);
    check("hold8_err", err_cnt - e0, 1);
    check("hold8_valid", valid_cnt - v0, 1);
    check("hold8_code", int'(key_code), 7);
    SW = '0;
    cycles(40);
    check("hold_release_err", err_cnt - e0, 1);
    single_press(9);

    // Reset asserted mid-debounce with SW[1] still high.
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    SW[1] = 1'b1;
    cycles(10);
    rst = 1'b0;
    cycles(2);
    check("midrst_code", int'(key_code), 0);
    check("midrst_stable", int'(sw_stable), 0);
    cycles(20);
    check("midrst_valid", valid_cnt - v0, 0);
    check("midrst_err", err_cnt - e0, 0);
    rst = 1'b1;
    e1 = cyc + 1;
    cycles(40);
    check("postrst_valid", valid_cnt - v0, 1);
    check("postrst_code", last_code, 1);
    check("postrst_lat", valid_cyc - e1 + 1, LAT);
    check("postrst_err", err_cnt - e0, 0);
    SW = '0;
    cycles(40);

    check("valid_err_overlap", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sw_key_encoder.md
SW_KEY_ENCODER -- requirements
Module: sw_key_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a switch change is accepted (board builds use 500000).
REQ-002 Parameter NUM_SW, default 10: number of switch inputs.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 SW  input  10  raw, asynchronous slide-switch levels.
REQ-006 key_valid  output  1  one-cycle pulse: a single clean key press accepted.
REQ-007 key_code  output  4  index 0..9 of the accepted switch; held until the next key_valid.
REQ-008 key_err  output  1  one-cycle pulse: a press was rejected.
REQ-009 sw_stable  output  10  debounced switch levels.

Function
REQ-010 Each SW bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Per switch, a counter SHALL increment while the synchronized value differs from sw_stable, and clear when they match.
- When the counter reaches DEBOUNCE_CYCLES, the corresponding sw_stable bit SHALL toggle and the counter SHALL clear.
REQ-012 A rising edge of a sw_stable bit SHALL be the only press event; falling edges SHALL generate no event.
REQ-013 FSM states SHALL be IDLE (all sw_stable low) and HELD (at least one sw_stable high).
REQ-014 In IDLE, exactly one press event in a cycle SHALL produce key_valid=1 and key_code=index on the next edge, and the FSM SHALL enter HELD.
REQ-015 In IDLE, two or more simultaneous press events SHALL produce key_err=1, leave key_code unchanged, and enter HELD.
REQ-016 In HELD, any press event SHALL produce key_err=1 with no key_valid; the FSM SHALL stay in HELD.
REQ-017 HELD SHALL return to IDLE on the cycle all sw_stable bits are low; no output pulse accompanies this transition.
REQ-018 Latency: key_valid SHALL be high at edge DEBOUNCE_CYCLES+4, counting edge 1 as the first edge sampling SW high.
REQ-019 Glitches shorter than DEBOUNCE_CYCLES cycles after synchronization SHALL leave sw_stable unchanged.
REQ-020 key_valid and key_err SHALL never be high in the same cycle.
REQ-021 A press event and a full release in the same cycle cannot occur (the press keeps the FSM in HELD); no special case is required.

Reset
REQ-022 rst low SHALL immediately clear the synchronizers, counters, sw_stable, key_valid, key_err and key_code (to 0), and force the FSM to IDLE.
REQ-023 A switch held high across reset release SHALL be treated as a new press after the full debounce latency.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL be emitted.

Structure
REQ-025 Package sw_key_pkg SHALL hold NUM_SW, KEY_W=4, the default DEBOUNCE_CYCLES, and the IDLE/HELD state encoding.
REQ-026 Sub-module sw_debounce (synchronizer, counter and stable flop for one bit) SHALL be instantiated NUM_SW times by a generate loop.
REQ-027 The counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).
REQ-028 The FSM and the encoder SHALL reside in sw_key_encoder.
REQ-029 key_code, key_valid and key_err SHALL drive the password stage's key input directly.

Verification (DEBOUNCE_CYCLES=16, 20 ns clock)
REQ-030 Hold rst low for 50 cycles, then release, with SW=0.
- Required: all outputs 0 throughout; no pulse.
REQ-031 Press SW[2] for 50 cycles, release, then do the same for SW[0], SW[1] and SW[6].
- Required: four key_valid pulses with key_code 2, 0, 1, 6, each at latency 20 cycles.
- Required: key_err stays 0.
REQ-032 Toggle SW[3] high for 10 cycles, then low.
- Required: sw_stable[3] stays 0; no key_valid.
REQ-033 Raise SW[4] and SW[5] on the same edge.
- Required: one key_err pulse; no key_valid; key_code keeps its previous value.
REQ-034 Hold SW[7], then raise SW[8] 40 cycles later.
- Required: key_valid with key_code=7, then key_err for SW[8].
- Required: after both are released, pressing SW[9] gives key_valid with key_code=9.
REQ-035 Raise SW[1], then assert rst low at cycle 10.
- Required: no pulse is emitted during reset.
- Required: after release with SW[1] still high, key_valid with key_code=1 at 20 cycles.
